// File: rtl/uart_apb_sequencer_pkg.sv
// Shared types and constants for the UART APB sequencer: FSM states, UART register
// word addresses and LSR bit positions. RD_RBR exists only with UART_APB_SEQUENCER_RX_EN.
package uart_apb_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG_DIV1,
    CFG_DIV2,
    CFG_LCR,
    CFG_FCR,
    CFG_IER,
    POLL_LSR,
`ifdef UART_APB_SEQUENCER_RX_EN
    RD_RBR,
`endif
    WR_THR
  } seq_state_e;

  localparam logic [31:0] ADDR_RBR  = 32'h0000_0000;
  localparam logic [31:0] ADDR_THR  = 32'h0000_0000;
  localparam logic [31:0] ADDR_IER  = 32'h0000_0004;
  localparam logic [31:0] ADDR_FCR  = 32'h0000_0008;
  localparam logic [31:0] ADDR_LCR  = 32'h0000_000C;
  localparam logic [31:0] ADDR_LSR  = 32'h0000_0014;
  localparam logic [31:0] ADDR_DIV1 = 32'h0000_001C;
  localparam logic [31:0] ADDR_DIV2 = 32'h0000_0020;

  localparam int unsigned LSR_DR   = 0;
  localparam int unsigned LSR_PE   = 2;
  localparam int unsigned LSR_FE   = 3;
  localparam int unsigned LSR_BI   = 4;
  localparam int unsigned LSR_THRE = 5;

  function automatic logic [31:0] zext8(input logic [7:0] b);
    return {24'h00_0000, b};
  endfunction

endpackage

// File: rtl/uart_apb_sequencer_master.sv
// uart_apb_master: single-outstanding APB master running SETUP then ACCESS until PREADY.
// Address/data/direction are latched when req is accepted and cleared when the transfer ends.
module uart_apb_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_e;

  phase_e      phase_q, phase_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;

  always_comb begin
    phase_d  = phase_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    case (phase_q)
      PH_IDLE: if (req) begin
        phase_d  = PH_SETUP;
        paddr_d  = addr;
        pwdata_d = wdata;
        pwrite_d = we;
      end
      PH_SETUP: phase_d = PH_ACCESS;
      PH_ACCESS: if (pready) begin
        phase_d  = PH_IDLE;
        paddr_d  = '0;
        pwdata_d = '0;
        pwrite_d = 1'b0;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PH_IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  assign psel    = (phase_q != PH_IDLE);
  assign penable = (phase_q == PH_ACCESS);
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign done    = penable && pready;
  assign rdata   = prdata;
  assign err     = done && pslverr;

endmodule

// File: rtl/uart_apb_sequencer.sv
// UART APB sequencer: configures a 16550-style UART over APB, then polls LSR to move
// bytes between the UART and the tx/rx streams. RX path gated by UART_APB_SEQUENCER_RX_EN.
module uart_apb_sequencer
  import uart_apb_seq_pkg::*;
#(
  parameter logic [15:0] DIVISOR  = 16'd54,
  parameter logic [7:0]  LCR_INIT = 8'h03,
  parameter logic [7:0]  FCR_INIT = 8'h06,
  parameter logic [7:0]  IER_INIT = 8'h00
) (
  input  logic        PCLK,
  input  logic        PRESET,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic [2:0]  rx_err,
  input  logic        rx_ready,
  output logic        cfg_done,
  output logic        apb_err
);

  seq_state_e  state_q, state_d;
  logic        issued_q, issued_d;
  logic        cfg_done_q, cfg_done_d;
  logic        apb_err_q, apb_err_d;
  logic        req, req_we, done, err;
  logic [31:0] req_addr, req_wdata, rdata;

  // Request decode: each state issues exactly one transfer, tracked by issued_q.
  always_comb begin
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    case (state_q)
      CFG_DIV1: begin req_we = 1'b1; req_addr = ADDR_DIV1; req_wdata = zext8(DIVISOR[7:0]);  end
      CFG_DIV2: begin req_we = 1'b1; req_addr = ADDR_DIV2; req_wdata = zext8(DIVISOR[15:8]); end
      CFG_LCR:  begin req_we = 1'b1; req_addr = ADDR_LCR;  req_wdata = zext8(LCR_INIT);      end
      CFG_FCR:  begin req_we = 1'b1; req_addr = ADDR_FCR;  req_wdata = zext8(FCR_INIT);      end
      CFG_IER:  begin req_we = 1'b1; req_addr = ADDR_IER;  req_wdata = zext8(IER_INIT);      end
      POLL_LSR: req_addr = ADDR_LSR;
`ifdef UART_APB_SEQUENCER_RX_EN
      RD_RBR:   req_addr = ADDR_RBR;
`endif
      WR_THR:   begin req_we = 1'b1; req_addr = ADDR_THR;  req_wdata = zext8(tx_data);       end
      default:  req_we = 1'b0;
    endcase
    req = (state_q != IDLE) && !issued_q;
  end

`ifdef UART_APB_SEQUENCER_RX_EN
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [2:0] rx_err_q, rx_err_d;
  logic [2:0] lsr_err_q, lsr_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    cfg_done_d = cfg_done_q;
    apb_err_d  = apb_err_q | err;
    issued_d   = done ? 1'b0 : (issued_q | req);
`ifdef UART_APB_SEQUENCER_RX_EN
    rx_valid_d = rx_valid_q & ~rx_ready;
    rx_data_d  = rx_data_q;
    rx_err_d   = rx_err_q;
    lsr_err_d  = lsr_err_q;
`endif
    case (state_q)
      IDLE:     state_d = CFG_DIV1;
      CFG_DIV1: if (done) state_d = CFG_DIV2;
      CFG_DIV2: if (done) state_d = CFG_LCR;
      CFG_LCR:  if (done) state_d = CFG_FCR;
      CFG_FCR:  if (done) state_d = CFG_IER;
      CFG_IER:  if (done) begin
        state_d    = POLL_LSR;
        cfg_done_d = 1'b1;
      end
      POLL_LSR: if (done) begin
`ifdef UART_APB_SEQUENCER_RX_EN
        lsr_err_d = {rdata[LSR_BI], rdata[LSR_FE], rdata[LSR_PE]};
        if (rdata[LSR_DR] && !rx_valid_q)           state_d = RD_RBR;
        else if (rdata[LSR_THRE] && tx_valid)       state_d = WR_THR;
`else
        if (rdata[LSR_THRE] && tx_valid)            state_d = WR_THR;
`endif
      end
`ifdef UART_APB_SEQUENCER_RX_EN
      RD_RBR: if (done) begin
        state_d    = POLL_LSR;
        rx_valid_d = 1'b1;
        rx_data_d  = rdata[7:0];
        rx_err_d   = lsr_err_q;
      end
`endif
      WR_THR:   if (done) state_d = POLL_LSR;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      issued_q   <= 1'b0;
      cfg_done_q <= 1'b0;
      apb_err_q  <= 1'b0;
`ifdef UART_APB_SEQUENCER_RX_EN
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_err_q   <= '0;
      lsr_err_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      cfg_done_q <= cfg_done_d;
      apb_err_q  <= apb_err_d;
`ifdef UART_APB_SEQUENCER_RX_EN
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
      lsr_err_q  <= lsr_err_d;
`endif
    end
  end

  uart_apb_master u_apb (
    .clk     (PCLK),
    .rst     (PRESET),
    .req     (req),
    .we      (req_we),
    .addr    (req_addr),
    .wdata   (req_wdata),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .paddr   (PADDR),
    .pwdata  (PWDATA),
    .prdata  (PRDATA),
    .pready  (PREADY),
    .pslverr (PSLVERR)
  );

  // tx_ready follows PREADY in the THR completion cycle, so it cannot be a flop.
  assign tx_ready = done && (state_q == WR_THR);
  assign cfg_done = cfg_done_q;
  assign apb_err  = apb_err_q;

`ifdef UART_APB_SEQUENCER_RX_EN
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;
  logic unused_ok;
  assign unused_ok = &{1'b0, rdata};
`else
  assign rx_valid = 1'b0;
  assign rx_data  = '0;
  assign rx_err   = '0;
  logic unused_ok;
  assign unused_ok = &{1'b0, rdata, rx_ready};
`endif

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Scoreboard bench for uart_apb_sequencer: an APB UART slave model with wait-state and
// PSLVERR injection, expected transfers and RX bytes queued as stimulus is applied.
module tb_uart_apb_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, cfg_done, apb_err;
  logic [7:0]  tx_data, rx_data;
  logic [2:0]  rx_err;

  always #5 PCLK = ~PCLK;

  uart_apb_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .rx_ready(rx_ready),
    .cfg_done(cfg_done), .apb_err(apb_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } xfer_t;

  xfer_t       sb_q[$];
  logic [10:0] rx_src_q[$];   // {BI,FE,PE, byte} held by the slave's receive FIFO
  logic [10:0] rx_exp_q[$];

  int n_checks = 0;
  int n_errs   = 0;

  // slave model controls
  logic [31:0] wait_addr, err_addr;
  int          wait_n;
  logic        wait_armed = 1'b0, err_armed = 1'b0, thre = 1'b0;
  int          wait_target, wait_cnt;
  logic [31:0] s_addr, s_data;
  logic        s_we, prev_psel, cfg_exp_next;
  int          tx_pulses = 0, rbr_reads = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lsr_now();
    logic       dr;
    logic [2:0] e;
    dr = (rx_src_q.size() > 0);
    e  = dr ? rx_src_q[0][10:8] : 3'b000;
    return {2'b00, thre, e, 1'b0, dr};
  endfunction

  task automatic push_cfg();
    sb_q.push_back('{32'h1C, 1'b1, 32'h36});
    sb_q.push_back('{32'h20, 1'b1, 32'h00});
    sb_q.push_back('{32'h0C, 1'b1, 32'h03});
    sb_q.push_back('{32'h08, 1'b1, 32'h06});
    sb_q.push_back('{32'h04, 1'b1, 32'h00});
  endtask

  task automatic wait_cfg(input int max_cycles);
    for (int i = 0; i < max_cycles && !cfg_done; i++) begin
      @(negedge PCLK); #2;
    end
    check_eq("cfg_done_rise", cfg_done, 1);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (sb_q.size() + rx_exp_q.size()) != 0; i++) begin
      @(negedge PCLK); #2;
    end
    check_eq("drain", sb_q.size() + rx_exp_q.size(), 0);
  endtask

  // APB slave + protocol/scoreboard monitor
  initial begin
    xfer_t e;
    logic  exp_tx;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    prev_psel = 1'b0; cfg_exp_next = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        PREADY = 1'b0; PSLVERR = 1'b0; prev_psel = 1'b0; cfg_exp_next = 1'b0;
      end else begin
        if (PSEL && !PENABLE) begin
          wait_cnt = 0; s_addr = PADDR; s_data = PWDATA; s_we = PWRITE;
          wait_target = (wait_armed && PADDR == wait_addr) ? wait_n : 0;
          if (wait_armed && PADDR == wait_addr) wait_armed = 1'b0;
          PREADY = 1'b0; PSLVERR = 1'b0;
        end else if (PSEL && PENABLE) begin
          if (wait_cnt < wait_target) begin
            PREADY = 1'b0; PSLVERR = 1'b0; wait_cnt++;
          end else begin
            PREADY = 1'b1;
            if (PADDR == 32'h14) PRDATA = {24'h0, lsr_now()};
            else if (PADDR == 32'h00 && rx_src_q.size() > 0) PRDATA = {24'h0, rx_src_q[0][7:0]};
            else PRDATA = 32'h0;
            PSLVERR = err_armed && (PADDR == err_addr);
            if (PSLVERR) err_armed = 1'b0;
          end
        end else begin
          PREADY = 1'b0; PSLVERR = 1'b0;
        end
        #1;
        exp_tx = PSEL && PENABLE && PREADY && PWRITE && (PADDR == 32'h0);
        check_eq("tx_ready", tx_ready, exp_tx);
        if (tx_ready) tx_pulses++;
        if (!PSEL) begin
          check_eq("idle_addr", PADDR, 0);
          check_eq("idle_ctl_data", {PENABLE, PWRITE, PWDATA}, 0);
        end else if (!PENABLE) begin
          check_eq("setup_once", prev_psel, 0);
        end else begin
          check_eq("access_addr", PADDR, s_addr);
          check_eq("access_wd", {PWRITE, PWDATA}, {s_we, s_data});
        end
        if (cfg_exp_next) begin
          check_eq("cfg_done_after_ier", cfg_done, 1);
          cfg_exp_next = 1'b0;
        end
        if (PSEL && PENABLE && PREADY) begin
          if (!(PADDR == 32'h14 && !PWRITE)) begin
            if (sb_q.size() == 0) check_eq("unexpected_xfer", PADDR, 32'hFFFF_FFFF);
            else begin
              e = sb_q.pop_front();
              check_eq("xfer_addr", PADDR, e.addr);
              check_eq("xfer_wd", {PWRITE, PWDATA}, {e.we, e.data});
            end
          end
          if (!PWRITE && PADDR == 32'h00) begin
            rbr_reads++;
            if (rx_src_q.size() > 0) void'(rx_src_q.pop_front());
          end
          if (PWRITE && PADDR == 32'h04) begin
            check_eq("cfg_done_early", cfg_done, 0);
            cfg_exp_next = 1'b1;
          end
        end
`ifdef UART_APB_SEQUENCER_RX_EN
        if (rx_valid && rx_ready) begin
          if (rx_exp_q.size() == 0) check_eq("unexpected_rx", rx_valid, 0);
          else check_eq("rx_byte", {rx_err, rx_data}, rx_exp_q.pop_front());
        end
`else
        check_eq("rx_tied", {rx_valid, rx_data, rx_err}, 0);
`endif
        prev_psel = PSEL;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    repeat (3) @(negedge PCLK);
    #2;
    check_eq("rst_apb_ctl", {PSEL, PENABLE, PWRITE}, 0);
    check_eq("rst_paddr", PADDR, 0);
    check_eq("rst_pwdata", PWDATA, 0);
    check_eq("rst_misc", {tx_ready, rx_valid, rx_data, rx_err, cfg_done, apb_err}, 0);

    // configuration: 3 wait states on DIV1, PSLVERR on LCR
    push_cfg();
    wait_addr = 32'h1C; wait_n = 3; wait_armed = 1'b1;
    err_addr  = 32'h0C; err_armed = 1'b1;
    PRESET = 1'b0;
    wait_cfg(200);
    check_eq("apb_err_set", apb_err, 1);
    check_eq("cfg_queue_empty", sb_q.size(), 0);

    // RX before TX; tx_valid dropped during the THR transfer
    @(negedge PCLK); #2;
`ifdef UART_APB_SEQUENCER_RX_EN
    sb_q.push_back('{32'h00, 1'b0, 32'h00});
    rx_exp_q.push_back({3'b000, 8'h5A});
`endif
    sb_q.push_back('{32'h00, 1'b1, 32'hA5});
    rx_src_q.push_back({3'b000, 8'h5A});
    tx_pulses = 0;
    rx_ready = 1'b1; thre = 1'b1; tx_data = 8'hA5; tx_valid = 1'b1;
    for (int i = 0; i < 300 && !(PSEL && PWRITE && PADDR == 32'h0); i++) begin
      @(negedge PCLK); #2;
    end
    check_eq("thr_started", PSEL && PWRITE, 1);
    tx_valid = 1'b0; tx_data = 8'h00;
    drain(200);
    repeat (10) @(negedge PCLK);
    #2;
    check_eq("tx_pulse_count", tx_pulses, 1);
    rx_src_q.delete();

    // RX held off by rx_ready=0 with a second byte waiting
    thre = 1'b0; rx_ready = 1'b0; rbr_reads = 0;
    rx_src_q.push_back({3'b010, 8'h33});
    rx_src_q.push_back({3'b000, 8'h44});
`ifdef UART_APB_SEQUENCER_RX_EN
    sb_q.push_back('{32'h00, 1'b0, 32'h00});
    sb_q.push_back('{32'h00, 1'b0, 32'h00});
    rx_exp_q.push_back({3'b010, 8'h33});
    rx_exp_q.push_back({3'b000, 8'h44});
`endif
    repeat (20) @(negedge PCLK);
    #2;
`ifdef UART_APB_SEQUENCER_RX_EN
    check_eq("rx_hold_valid", rx_valid, 1);
    check_eq("rx_hold_byte", {rx_err, rx_data}, {3'b010, 8'h33});
    check_eq("rbr_reads_held", rbr_reads, 1);
    rx_ready = 1'b1;
    drain(200);
    check_eq("rbr_reads_total", rbr_reads, 2);
`else
    check_eq("rbr_reads_none", rbr_reads, 0);
    rx_ready = 1'b1;
    drain(20);
`endif
    check_eq("apb_err_sticky", apb_err, 1);
    rx_src_q.delete();

    // reset during DIV2 ACCESS
    PRESET = 1'b1;
    @(negedge PCLK); #2;
    check_eq("rst_clears_err", {apb_err, cfg_done}, 0);
    sb_q.delete();
    push_cfg();
    wait_addr = 32'h20; wait_n = 10; wait_armed = 1'b1;
    PRESET = 1'b0;
    for (int i = 0; i < 100 && !(PSEL && PENABLE && PADDR == 32'h20); i++) begin
      @(negedge PCLK); #2;
    end
    check_eq("div2_in_access", {PSEL, PENABLE, PADDR}, {2'b11, 32'h20});
    PRESET = 1'b1;
    #1;
    check_eq("rst_mid_xfer", {PSEL, PENABLE}, 0);
    check_eq("rst_mid_flags", {cfg_done, apb_err, tx_ready}, 0);
    @(negedge PCLK); #2;
    sb_q.delete();
    push_cfg();
    PRESET = 1'b0;
    wait_cfg(200);
    check_eq("cfg_rerun_queue", sb_q.size(), 0);
    check_eq("apb_err_clean", apb_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
